// File: rtl/ssd_scan_driver.sv
// Seven-segment scan engine: a shared double-dabble converter feeding a per-channel digit bank,
// time-multiplexed onto common anode/segment lines. Optional macro: SSD_LEADING_ZERO_BLANK_EN.
module ssd_scan_driver #(
  parameter int NUM_CH        = 2,
  parameter int DIGITS_PER_CH = 4,
  parameter int VALUE_W       = 16,
  parameter int DWELL_CYCLES  = 100000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CH*VALUE_W-1:0]       values,
  output logic [NUM_CH*DIGITS_PER_CH-1:0] anode,
  output logic [6:0]                      ssd_out,
  output logic                            conv_busy,
  output logic [NUM_CH-1:0]               overflow
);
  localparam int BCD_W   = DIGITS_PER_CH * 4;
  localparam int NUM_DIG = NUM_CH * DIGITS_PER_CH;
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int DIG_W   = (DIGITS_PER_CH > 1) ? $clog2(DIGITS_PER_CH) : 1;
  localparam int IDX_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam int CNT_W   = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
  localparam int DWELL_W = $clog2(DWELL_CYCLES);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} convState_t;

  convState_t                 state;
  logic [CH_W-1:0]            convCh;
  logic [CNT_W-1:0]           cnt;
  logic [VALUE_W-1:0]         sr;
  logic [BCD_W-1:0]           bcd;
  logic [BCD_W-1:0]           bcdAdj;
  logic                       ovfAcc;
  logic [NUM_CH*BCD_W-1:0]    bank;

  logic [DWELL_W-1:0]         dwell;
  logic [CH_W-1:0]            scanCh;
  logic [DIG_W-1:0]           scanDig;
  logic [IDX_W-1:0]           scanIdx;
  logic [BCD_W-1:0]           chanDigits;
  logic [3:0]                 nib;
  logic [6:0]                 segNext;

  function automatic logic [BCD_W-1:0] addThree(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS_PER_CH; i++)
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [6:0] decodeDigit(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  assign bcdAdj = addThree(bcd);

  // Converter control and committed digit bank
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      convCh    <= '0;
      cnt       <= '0;
      conv_busy <= 1'b0;
      bank      <= '0;
      overflow  <= '0;
    end else begin
      case (state)
        IDLE: begin
          state     <= SHIFT;
          cnt       <= '0;
          conv_busy <= 1'b1;
        end
        SHIFT: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(VALUE_W - 1)) state <= COMMIT;
        end
        COMMIT: begin
          bank[convCh*BCD_W +: BCD_W] <= bcd;
          overflow[convCh]            <= ovfAcc;
          conv_busy                   <= 1'b0;
          convCh <= (convCh == CH_W'(NUM_CH - 1)) ? '0 : convCh + CH_W'(1);
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Double-dabble datapath; any bit pushed past the top nibble means the value needs more digits
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        sr     <= values[convCh*VALUE_W +: VALUE_W];
        bcd    <= '0;
        ovfAcc <= 1'b0;
      end
      SHIFT: begin
        sr     <= {sr[VALUE_W-2:0], 1'b0};
        bcd    <= {bcdAdj[BCD_W-2:0], sr[VALUE_W-1]};
        ovfAcc <= ovfAcc | bcdAdj[BCD_W-1];
      end
      default: ;
    endcase
  end

  assign scanIdx = IDX_W'(scanCh * DIGITS_PER_CH) + IDX_W'(scanDig);

  always_comb begin
    chanDigits = bank[scanCh*BCD_W +: BCD_W];
    nib        = chanDigits[scanDig*4 +: 4];
    segNext    = decodeDigit(nib);
`ifdef SSD_LEADING_ZERO_BLANK_EN
    if (scanDig != '0 && (chanDigits >> (scanDig*4)) == '0) segNext = 7'b1111111;
`endif
    if (overflow[scanCh]) segNext = 7'b1111110;
  end

  // Scan sequencer and registered pin drivers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell   <= '0;
      scanCh  <= '0;
      scanDig <= '0;
      anode   <= '1;
      ssd_out <= 7'b1111111;
    end else begin
      anode   <= ~(NUM_DIG'(1) << scanIdx);
      ssd_out <= segNext;
      if (dwell == DWELL_W'(DWELL_CYCLES - 1)) begin
        dwell <= '0;
        if (scanDig == DIG_W'(DIGITS_PER_CH - 1)) begin
          scanDig <= '0;
          scanCh  <= (scanCh == CH_W'(NUM_CH - 1)) ? '0 : scanCh + CH_W'(1);
        end else begin
          scanDig <= scanDig + DIG_W'(1);
        end
      end else begin
        dwell <= dwell + DWELL_W'(1);
      end
    end
  end
endmodule
